// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared types and constants for the DAC SPI transmitter
package dac_spi_pkg;

   localparam int         FRAME_BITS  = 16;
   localparam logic [3:0] CMD_DEFAULT = 4'b0011;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT_HI,
      SHIFT_LO,
      HOLD,
      GAP
   } state_t;

   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0] cmd, input logic [7:0] sample);
      return {cmd, sample, 4'b0000};
   endfunction

endpackage

// File: rtl/sclk_phase_gen.sv
// sclk_phase_gen: counts CLK_DIV clk cycles per SCLK half-period and strobes on the last one
module sclk_phase_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic phase_end
);

   logic [7:0] cnt;

   assign phase_end = en && (cnt == 8'(CLK_DIV - 1));

   // restart from zero while disabled and after every completed phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else     cnt <= (!en || phase_end) ? '0 : cnt + 8'd1;
   end

endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises 8-bit samples into 16-bit mode-0 SPI frames {CMD, sample, 0000}
module dac_spi_tx
   import dac_spi_pkg::*;
#(
   parameter int         CLK_DIV = 2,
   parameter logic [3:0] CMD     = CMD_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic       sclk,
   output logic       cs_n,
   output logic       mosi,
   output logic       frame_done
);

   state_t                state, state_next;
   logic [FRAME_BITS-1:0] shreg, shreg_next;
   logic [3:0]            bit_cnt, bit_cnt_next;
   logic                  phase_end, accept, bit_end, shift;
   logic                  cs_n_next, sclk_next, mosi_next, din_ready_next, frame_done_next;

   assign accept  = (state == IDLE) && din_ready && din_valid;
   assign bit_end = (state == SHIFT_HI) && phase_end;
   assign shift   = bit_end && (bit_cnt != 4'd0);

   sclk_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
      .clk       (clk),
      .rst       (rst),
      .en        (state != IDLE),
      .phase_end (phase_end)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // next-state: every non-idle state lasts one phase; the last bit's high phase leads to HOLD
   always_comb begin
      state_next = state;
      case (state)
         IDLE:     state_next = accept    ? SETUP : IDLE;
         SETUP:    state_next = phase_end ? SHIFT_HI : SETUP;
         SHIFT_HI: state_next = phase_end ? ((bit_cnt == 4'd0) ? HOLD : SHIFT_LO) : SHIFT_HI;
         SHIFT_LO: state_next = phase_end ? SHIFT_HI : SHIFT_LO;
         HOLD:     state_next = phase_end ? GAP : HOLD;
         GAP:      state_next = phase_end ? IDLE : GAP;
         default:  state_next = IDLE;
      endcase
   end

   // shift register loads on accept and advances as each high phase ends (bit 0 is never shifted past)
   always_comb begin
      shreg_next   = accept ? build_frame(CMD, din) : (shift ? (shreg << 1) : shreg);
      bit_cnt_next = accept ? 4'(FRAME_BITS - 1) : (shift ? bit_cnt - 4'd1 : bit_cnt);
   end

   // output decode from the upcoming state, so every output is a register
   always_comb begin
      cs_n_next       = (state_next == IDLE) || (state_next == GAP);
      sclk_next       = state_next == SHIFT_HI;
      mosi_next       = ((state_next == SETUP) || (state_next == SHIFT_HI) || (state_next == SHIFT_LO))
                        ? shreg_next[FRAME_BITS-1] : 1'b0;
      din_ready_next  = state_next == IDLE;
      frame_done_next = (state == HOLD) && (state_next == GAP);
   end

   // datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg      <= '0;
         bit_cnt    <= '0;
         cs_n       <= 1'b1;
         sclk       <= 1'b0;
         mosi       <= 1'b0;
         din_ready  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         shreg      <= shreg_next;
         bit_cnt    <= bit_cnt_next;
         cs_n       <= cs_n_next;
         sclk       <= sclk_next;
         mosi       <= mosi_next;
         din_ready  <= din_ready_next;
         frame_done <= frame_done_next;
      end
   end

endmodule
